// File: rtl/warp_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : warp_mem_arbiter
// Description : Per-lane round-robin arbiter giving two warps' LSUs shared
//               access to one data-memory read/write channel set. Each lane
//               runs its own IDLE/ISSUE/RESPOND FSM with one transaction in
//               flight, and all outputs are registered.
//               Optional grant/conflict statistics: WARP_MEM_ARBITER_STATS_EN
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module warp_mem_arbiter #(
   parameter int THREADS_PER_BLOCK = 4,
   parameter int ADDR_BITS         = 8,
   parameter int DATA_BITS         = 8
)(
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [THREADS_PER_BLOCK-1:0]                 w1_read_valid,
   input  logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]  w1_read_address,
   output logic [THREADS_PER_BLOCK-1:0]                 w1_read_ready,
   output logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]  w1_read_data,
   input  logic [THREADS_PER_BLOCK-1:0]                 w1_write_valid,
   input  logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]  w1_write_address,
   input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]  w1_write_data,
   output logic [THREADS_PER_BLOCK-1:0]                 w1_write_ready,
   input  logic [THREADS_PER_BLOCK-1:0]                 w2_read_valid,
   input  logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]  w2_read_address,
   output logic [THREADS_PER_BLOCK-1:0]                 w2_read_ready,
   output logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]  w2_read_data,
   input  logic [THREADS_PER_BLOCK-1:0]                 w2_write_valid,
   input  logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]  w2_write_address,
   input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]  w2_write_data,
   output logic [THREADS_PER_BLOCK-1:0]                 w2_write_ready,
   output logic [THREADS_PER_BLOCK-1:0]                 mem_read_valid,
   output logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]  mem_read_address,
   input  logic [THREADS_PER_BLOCK-1:0]                 mem_read_ready,
   input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]  mem_read_data,
   output logic [THREADS_PER_BLOCK-1:0]                 mem_write_valid,
   output logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]  mem_write_address,
   output logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]  mem_write_data,
   input  logic [THREADS_PER_BLOCK-1:0]                 mem_write_ready
`ifdef WARP_MEM_ARBITER_STATS_EN
   ,
   output logic [15:0]                                  grant_count_1,
   output logic [15:0]                                  grant_count_2,
   output logic [15:0]                                  conflict_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

`ifdef WARP_MEM_ARBITER_STATS_EN
   logic [THREADS_PER_BLOCK-1:0] w_gnt1_v;
   logic [THREADS_PER_BLOCK-1:0] w_gnt2_v;
   logic [THREADS_PER_BLOCK-1:0] w_conf_v;
`endif

   for (genvar l = 0; l < THREADS_PER_BLOCK; l++) begin : g_lane
      state_t               r_state, w_state_nx;
      logic                 r_ptr, w_ptr_nx;     // 0 = warp 1 has priority, 1 = warp 2
      logic                 r_wid, w_wid_nx;     // granted warp (0 = warp 1)
      logic                 r_op, w_op_nx;       // 0 = read, 1 = write
      logic [ADDR_BITS-1:0] r_addr, w_addr_nx;
      logic [DATA_BITS-1:0] r_wdata, w_wdata_nx;
      logic [DATA_BITS-1:0] r_rdata, w_rdata_nx;
      logic                 r_mrv, w_mrv_nx;
      logic                 r_mwv, w_mwv_nx;
      logic                 r_w1rr, w_w1rr_nx;
      logic                 r_w1wr, w_w1wr_nx;
      logic                 r_w2rr, w_w2rr_nx;
      logic                 r_w2wr, w_w2wr_nx;
      logic                 w_req1, w_req2, w_sel, w_sel_rd, w_grant, w_resp_valid;

      assign w_req1   = w1_read_valid[l] | w1_write_valid[l];
      assign w_req2   = w2_read_valid[l] | w2_write_valid[l];
      // Contention resolved by the pointer; otherwise whichever warp asks.
      assign w_sel    = (w_req1 && w_req2) ? r_ptr : w_req2;
      // A warp raising both read and write is served read first.
      assign w_sel_rd = w_sel ? w2_read_valid[l] : w1_read_valid[l];
      assign w_grant  = (r_state == S_IDLE) && (w_req1 || w_req2) &&
                        !mem_read_ready[l] && !mem_write_ready[l];
      assign w_resp_valid = r_op ? (r_wid ? w2_write_valid[l] : w1_write_valid[l])
                                 : (r_wid ? w2_read_valid[l]  : w1_read_valid[l]);

      // Next-state and next-output computation for this lane
      always_comb begin
         w_state_nx = r_state;
         w_ptr_nx   = r_ptr;
         w_wid_nx   = r_wid;
         w_op_nx    = r_op;
         w_addr_nx  = r_addr;
         w_wdata_nx = r_wdata;
         w_rdata_nx = r_rdata;
         w_mrv_nx   = r_mrv;
         w_mwv_nx   = r_mwv;
         w_w1rr_nx  = r_w1rr;
         w_w1wr_nx  = r_w1wr;
         w_w2rr_nx  = r_w2rr;
         w_w2wr_nx  = r_w2wr;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  w_state_nx = S_ISSUE;
                  w_wid_nx   = w_sel;
                  w_op_nx    = ~w_sel_rd;
                  w_ptr_nx   = ~w_sel;
                  w_mrv_nx   = w_sel_rd;
                  w_mwv_nx   = ~w_sel_rd;
                  w_wdata_nx = w_sel ? w2_write_data[l] : w1_write_data[l];
                  if (w_sel_rd)
                     w_addr_nx = w_sel ? w2_read_address[l] : w1_read_address[l];
                  else
                     w_addr_nx = w_sel ? w2_write_address[l] : w1_write_address[l];
               end
            end
            S_ISSUE: begin
               if (!r_op && mem_read_ready[l]) begin
                  w_rdata_nx = mem_read_data[l];
                  w_mrv_nx   = 1'b0;
                  w_w1rr_nx  = ~r_wid;
                  w_w2rr_nx  = r_wid;
                  w_state_nx = S_RESPOND;
               end else if (r_op && mem_write_ready[l]) begin
                  w_mwv_nx   = 1'b0;
                  w_w1wr_nx  = ~r_wid;
                  w_w2wr_nx  = r_wid;
                  w_state_nx = S_RESPOND;
               end
            end
            S_RESPOND: begin
               if (!w_resp_valid) begin
                  w_w1rr_nx  = 1'b0;
                  w_w1wr_nx  = 1'b0;
                  w_w2rr_nx  = 1'b0;
                  w_w2wr_nx  = 1'b0;
                  w_state_nx = S_IDLE;
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end

      // Lane state and registered outputs
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_wid   <= 1'b0;
            r_op    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_mrv   <= 1'b0;
            r_mwv   <= 1'b0;
            r_w1rr  <= 1'b0;
            r_w1wr  <= 1'b0;
            r_w2rr  <= 1'b0;
            r_w2wr  <= 1'b0;
         end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_wid   <= w_wid_nx;
            r_op    <= w_op_nx;
            r_addr  <= w_addr_nx;
            r_wdata <= w_wdata_nx;
            r_rdata <= w_rdata_nx;
            r_mrv   <= w_mrv_nx;
            r_mwv   <= w_mwv_nx;
            r_w1rr  <= w_w1rr_nx;
            r_w1wr  <= w_w1wr_nx;
            r_w2rr  <= w_w2rr_nx;
            r_w2wr  <= w_w2wr_nx;
         end
      end

      assign mem_read_valid[l]    = r_mrv;
      assign mem_read_address[l]  = r_addr;
      assign mem_write_valid[l]   = r_mwv;
      assign mem_write_address[l] = r_addr;
      assign mem_write_data[l]    = r_wdata;
      assign w1_read_ready[l]     = r_w1rr;
      assign w1_write_ready[l]    = r_w1wr;
      assign w2_read_ready[l]     = r_w2rr;
      assign w2_write_ready[l]    = r_w2wr;
      assign w1_read_data[l]      = r_rdata;
      assign w2_read_data[l]      = r_rdata;
`ifdef WARP_MEM_ARBITER_STATS_EN
      assign w_gnt1_v[l] = w_grant & ~w_sel;
      assign w_gnt2_v[l] = w_grant & w_sel;
      assign w_conf_v[l] = (r_state == S_IDLE) & w_req1 & w_req2;
`endif
   end

`ifdef WARP_MEM_ARBITER_STATS_EN
   logic [15:0] r_gc1, r_gc2, r_cc;

   function automatic logic [15:0] sat_add(input logic [15:0] a,
                                           input logic [THREADS_PER_BLOCK-1:0] v);
      logic [16:0] s;
      s = {1'b0, a};
      for (int i = 0; i < THREADS_PER_BLOCK; i++) s = s + {16'd0, v[i]};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   // Saturating per-cycle accumulation of lane grant and conflict events
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gc1 <= '0;
         r_gc2 <= '0;
         r_cc  <= '0;
      end else begin
         r_gc1 <= sat_add(r_gc1, w_gnt1_v);
         r_gc2 <= sat_add(r_gc2, w_gnt2_v);
         r_cc  <= sat_add(r_cc,  w_conf_v);
      end
   end

   assign grant_count_1  = r_gc1;
   assign grant_count_2  = r_gc2;
   assign conflict_count = r_cc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_warp_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_warp_mem_arbiter
// Description : Directed vector table plus hand sequences for warp_mem_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_warp_mem_arbiter;
   localparam int T = 4;

   logic clk = 1'b0;
   logic reset;
   logic [T-1:0]      w1_read_valid, w1_read_ready, w1_write_valid, w1_write_ready;
   logic [T-1:0]      w2_read_valid, w2_read_ready, w2_write_valid, w2_write_ready;
   logic [T-1:0][7:0] w1_read_address, w1_read_data, w1_write_address, w1_write_data;
   logic [T-1:0][7:0] w2_read_address, w2_read_data, w2_write_address, w2_write_data;
   logic [T-1:0]      mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
   logic [T-1:0][7:0] mem_read_address, mem_read_data, mem_write_address, mem_write_data;
`ifdef WARP_MEM_ARBITER_STATS_EN
   logic [15:0] grant_count_1, grant_count_2, conflict_count;
`endif

   warp_mem_arbiter #(.THREADS_PER_BLOCK(T), .ADDR_BITS(8), .DATA_BITS(8)) dut (
      .clk(clk), .reset(reset),
      .w1_read_valid(w1_read_valid), .w1_read_address(w1_read_address),
      .w1_read_ready(w1_read_ready), .w1_read_data(w1_read_data),
      .w1_write_valid(w1_write_valid), .w1_write_address(w1_write_address),
      .w1_write_data(w1_write_data), .w1_write_ready(w1_write_ready),
      .w2_read_valid(w2_read_valid), .w2_read_address(w2_read_address),
      .w2_read_ready(w2_read_ready), .w2_read_data(w2_read_data),
      .w2_write_valid(w2_write_valid), .w2_write_address(w2_write_address),
      .w2_write_data(w2_write_data), .w2_write_ready(w2_write_ready),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
`ifdef WARP_MEM_ARBITER_STATS_EN
      , .grant_count_1(grant_count_1), .grant_count_2(grant_count_2),
      .conflict_count(conflict_count)
`endif
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // vin = {w1 rd, w1 wr, w2 rd, w2 wr}; rdy = {mem rd ready, mem wr ready}
   // ex  = {mem rd valid, mem wr valid, w1 rd rdy, w1 wr rdy, w2 rd rdy, w2 wr rdy}
   typedef struct {
      int         lane;
      logic [3:0] vin;
      logic [1:0] rdy;
      logic [5:0] ex;
      logic [7:0] eaddr;
      logic [7:0] ewd;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int lane, input logic [3:0] vin, input logic [1:0] rdy,
                      input logic [5:0] ex, input logic [7:0] ea, input logic [7:0] ewd);
      vec_t v;
      v.lane = lane; v.vin = vin; v.rdy = rdy; v.ex = ex; v.eaddr = ea; v.ewd = ewd;
      tbl.push_back(v);
   endtask

   task automatic clear_inputs();
      w1_read_valid = '0; w1_write_valid = '0;
      w2_read_valid = '0; w2_write_valid = '0;
      mem_read_ready = '0; mem_write_ready = '0;
   endtask

   task automatic set_constants();
      for (int i = 0; i < T; i++) begin
         w1_read_address[i] = 8'h10; w1_write_address[i] = 8'h20; w1_write_data[i] = 8'h11;
         w2_read_address[i] = 8'h30; w2_write_address[i] = 8'h21; w2_write_data[i] = 8'h22;
         mem_read_data[i]   = 8'hA5;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic any_hs();
      return |{w1_read_ready, w1_write_ready, w2_read_ready, w2_write_ready,
               mem_read_valid, mem_write_valid};
   endfunction

   initial begin
      logic [29:0] act, exp;
      logic [7:0]  a_addr, a_wd, a_rd;
      int          order[$];
      logic        p1, p2;
      int          l;

      reset = 1'b1;
      clear_inputs();
      set_constants();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_state", 64'(|{w1_read_ready, w1_read_data, w1_write_ready,
                                 w2_read_ready, w2_read_data, w2_write_ready,
                                 mem_read_valid, mem_read_address, mem_write_valid,
                                 mem_write_address, mem_write_data}), 64'd0);

      // Lane 0: lone w1 read, memory answers on the third ISSUE cycle
      add(0, 4'b1000, 2'b00, 6'b100000, 8'h10, 8'h00);
      add(0, 4'b1000, 2'b01, 6'b100000, 8'h10, 8'h00);
      add(0, 4'b1000, 2'b00, 6'b100000, 8'h10, 8'h00);
      add(0, 4'b1000, 2'b10, 6'b001000, 8'h00, 8'h00);
      add(0, 4'b0000, 2'b00, 6'b000000, 8'h00, 8'h00);
      add(0, 4'b1000, 2'b10, 6'b000000, 8'h00, 8'h00);   // no grant while mem ready high
      add(0, 4'b1000, 2'b00, 6'b100000, 8'h10, 8'h00);
      add(0, 4'b1000, 2'b10, 6'b001000, 8'h00, 8'h00);
      add(0, 4'b0000, 2'b00, 6'b000000, 8'h00, 8'h00);
      // Lane 1: both warps write in the same cycle, w1 first then w2
      add(1, 4'b0101, 2'b00, 6'b010000, 8'h20, 8'h11);
      add(1, 4'b0101, 2'b01, 6'b000100, 8'h00, 8'h00);
      add(1, 4'b0001, 2'b00, 6'b000000, 8'h00, 8'h00);
      add(1, 4'b0001, 2'b00, 6'b010000, 8'h21, 8'h22);
      add(1, 4'b0001, 2'b01, 6'b000001, 8'h00, 8'h00);
      add(1, 4'b0000, 2'b00, 6'b000000, 8'h00, 8'h00);
      // Lane 3: w1 raises read and write together; read wins, write stays pending
      add(3, 4'b1100, 2'b00, 6'b100000, 8'h10, 8'h00);
      add(3, 4'b1100, 2'b10, 6'b001000, 8'h00, 8'h00);
      add(3, 4'b0100, 2'b00, 6'b000000, 8'h00, 8'h00);
      add(3, 4'b0100, 2'b00, 6'b010000, 8'h20, 8'h11);
      add(3, 4'b0100, 2'b01, 6'b000100, 8'h00, 8'h00);
      add(3, 4'b0000, 2'b00, 6'b000000, 8'h00, 8'h00);

      foreach (tbl[i]) begin
         l = tbl[i].lane;
         @(negedge clk);
         clear_inputs();
         w1_read_valid[l]   = tbl[i].vin[3];
         w1_write_valid[l]  = tbl[i].vin[2];
         w2_read_valid[l]   = tbl[i].vin[1];
         w2_write_valid[l]  = tbl[i].vin[0];
         mem_read_ready[l]  = tbl[i].rdy[1];
         mem_write_ready[l] = tbl[i].rdy[0];
         @(posedge clk);
         #1;
         a_addr = tbl[i].ex[5] ? mem_read_address[l] :
                  tbl[i].ex[4] ? mem_write_address[l] : 8'h00;
         a_wd   = tbl[i].ex[4] ? mem_write_data[l] : 8'h00;
         a_rd   = tbl[i].ex[3] ? w1_read_data[l] : tbl[i].ex[1] ? w2_read_data[l] : 8'h00;
         act = {mem_read_valid[l], mem_write_valid[l], w1_read_ready[l], w1_write_ready[l],
                w2_read_ready[l], w2_write_ready[l], a_addr, a_wd, a_rd};
         exp = {tbl[i].ex, tbl[i].eaddr, tbl[i].ewd,
                (tbl[i].ex[3] | tbl[i].ex[1]) ? 8'hA5 : 8'h00};
         check($sformatf("vec%0d_lane%0d", i, l), 64'(act), 64'(exp));
      end

      // Lane 2: both warps keep re-requesting reads; grants must alternate
      p1 = 1'b0; p2 = 1'b0;
      for (int cyc = 0; cyc < 100 && order.size() < 6; cyc++) begin
         @(negedge clk);
         w1_read_valid[2]  = ~w1_read_ready[2];
         w2_read_valid[2]  = ~w2_read_ready[2];
         mem_read_ready[2] = mem_read_valid[2];
         @(posedge clk);
         #1;
         if (w1_read_ready[2] && !p1) order.push_back(1);
         if (w2_read_ready[2] && !p2) order.push_back(2);
         p1 = w1_read_ready[2];
         p2 = w2_read_ready[2];
      end
      check("alt_grant_count", 64'(order.size()), 64'd6);
      foreach (order[i]) check($sformatf("alt_grant%0d", i), 64'(order[i]), 64'((i % 2 == 0) ? 1 : 2));
      @(negedge clk);
      clear_inputs();
      repeat (2) @(posedge clk);

      // Lane 0: w2 changes its read address while the request is in ISSUE
      @(negedge clk);
      w2_read_valid[0] = 1'b1;
      @(posedge clk); #1;
      check("issue_addr", 64'({mem_read_valid[0], mem_read_address[0]}), 64'({1'b1, 8'h30}));
      @(negedge clk);
      w2_read_address[0] = 8'h77;
      repeat (2) begin
         @(posedge clk); #1;
         check("issue_addr_hold", 64'({mem_read_valid[0], mem_read_address[0]}), 64'({1'b1, 8'h30}));
      end
      @(negedge clk);
      mem_read_data[0]  = 8'h5C;
      mem_read_ready[0] = 1'b1;
      @(posedge clk); #1;
      check("w2_read_resp", 64'({mem_read_valid[0], w2_read_ready[0], w1_read_ready[0], w2_read_data[0]}),
            64'({1'b0, 1'b1, 1'b0, 8'h5C}));
      @(negedge clk);
      clear_inputs();
      set_constants();
      @(posedge clk); #1;
      check("w2_read_done", 64'(w2_read_ready[0]), 64'd0);

      // Lane 3: reset while in RESPOND; pointer must return to warp 1
      @(negedge clk);
      w1_write_valid[3] = 1'b1;
      @(posedge clk); #1;
      check("l3_write_issue", 64'({mem_write_valid[3], mem_write_address[3]}), 64'({1'b1, 8'h20}));
      @(negedge clk);
      mem_write_ready[3] = 1'b1;
      @(posedge clk); #1;
      check("l3_write_respond", 64'(w1_write_ready[3]), 64'd1);
      @(negedge clk);
      mem_write_ready[3] = 1'b0;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", 64'(any_hs()), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      w1_write_valid[3] = 1'b1;
      w2_write_valid[3] = 1'b1;
      @(posedge clk); #1;
      check("ptr_after_reset", 64'({mem_write_valid[3], mem_write_address[3], mem_write_data[3]}),
            64'({1'b1, 8'h20, 8'h11}));

      // All four lanes contended in one cycle after a fresh reset
      do_reset();
      w1_read_valid = '1;
      w2_read_valid = '1;
      @(posedge clk); #1;
      check("all_lanes_grant_w1", 64'({mem_read_valid, mem_read_address}),
            64'({4'hF, 8'h10, 8'h10, 8'h10, 8'h10}));
`ifdef WARP_MEM_ARBITER_STATS_EN
      check("conflict_count", 64'(conflict_count), 64'd4);
      check("grant_count_1", 64'(grant_count_1), 64'd4);
      check("grant_count_2", 64'(grant_count_2), 64'd0);
      @(posedge clk); #1;
      check("stats_hold_in_issue", 64'({conflict_count, grant_count_1, grant_count_2}),
            64'({16'd4, 16'd4, 16'd0}));
`endif
      @(negedge clk);
      clear_inputs();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
